bram_burst_control: RTL and testbench

BRAM_BURST_CONTROL -- requirements
Module: bram_burst_control

---
 rtl/bram_burst_control.sv | 139 +++++++++++++
 tb/tb_bram_burst_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_control.sv
// bram_burst_control
// Sequences fixed-length read or write bursts into one of several BRAM banks.
// A burst is requested with i_start in IDLE. The target bank must exist; if it
// does not, the request is refused with a one-cycle o_err pulse. Each
// unstalled WRITE/READ cycle issues one beat: it raises the selected bank's
// enable and advances the address, which wraps modulo 2**ADDR_W. A single
// DONE cycle follows the last beat.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_start      burst request (sampled in IDLE only)
//   i_rw         direction sampled with i_start: 1 = write, 0 = read
//   i_base_addr  first beat address, sampled with i_start
//   i_bank_sel   target bank index, sampled with i_start
//   i_stall      holds the burst; no beat while high
//   o_bram_addr  registered beat address
//   o_wen/o_ren  one-hot per-bank write/read enables (combinational)
//   o_busy       high in WRITE, READ and DONE
//   o_done       one-cycle pulse in DONE
//   o_err        one-cycle pulse after a rejected start
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a start request
// WRITE | issuing write beats to the latched bank
// READ  | issuing read beats to the latched bank
// DONE  | single completion cycle, then back to IDLE
module bram_burst_control #(
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int NUM_BANKS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_rw,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [2:0]           i_bank_sel,
    input  logic                 i_stall,
    output logic [ADDR_W-1:0]    o_bram_addr,
    output logic [NUM_BANKS-1:0] o_wen,
    output logic [NUM_BANKS-1:0] o_ren,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_cnt;
    logic [2:0]           r_bank;
    logic                 r_err;

    logic                 w_bank_ok;
    logic                 w_accept;
    logic                 w_beat;
    logic                 w_last;
    logic [NUM_BANKS-1:0] w_sel;

    // Direction is held by the state itself (WRITE vs READ), so rw needs no
    // separate register once the burst has started.
    assign w_bank_ok = ({1'b0, i_bank_sel} < 4'(NUM_BANKS));
    assign w_accept  = (r_state == S_IDLE) && i_start && w_bank_ok;
    assign w_beat    = ((r_state == S_WRITE) || (r_state == S_READ)) && !i_stall;
    // BURST_LEN-1 always fits in ADDR_W bits since BURST_LEN <= 2**ADDR_W.
    assign w_last    = (r_cnt == ADDR_W'(BURST_LEN - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = i_rw ? S_WRITE : S_READ;
                end
            end
            S_WRITE, S_READ: begin
                if (w_beat && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Burst datapath: address, beat counter, latched bank, error pulse
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_bank <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && i_start && !w_bank_ok;
            if (w_accept) begin
                r_addr <= i_base_addr;
                r_cnt  <= '0;
                r_bank <= i_bank_sel;
            end else if (w_beat) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt + ADDR_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        w_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_sel[b] = (r_bank == 3'(b));
        end
        o_wen       = ((r_state == S_WRITE) && !i_stall) ? w_sel : '0;
        o_ren       = ((r_state == S_READ)  && !i_stall) ? w_sel : '0;
        o_bram_addr = r_addr;
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_err       = r_err;
    end

endmodule

// File: tb/tb_bram_burst_control.sv
module tb_bram_burst_control;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_start;
    logic       i_rw;
    logic [3:0] i_base_addr;
    logic [2:0] i_bank_sel;
    logic       i_stall;
    logic [3:0] o_bram_addr;
    logic [1:0] o_wen;
    logic [1:0] o_ren;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    // Second instance: single-beat bursts, 3-bit address, 4 banks
    logic       s_start;
    logic       s_rw;
    logic [2:0] s_base_addr;
    logic [2:0] s_bank_sel;
    logic       s_stall;
    logic [2:0] s_bram_addr;
    logic [3:0] s_wen;
    logic [3:0] s_ren;
    logic       s_busy;
    logic       s_done;
    logic       s_err;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    bram_burst_control u_dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_rw        (i_rw),
        .i_base_addr (i_base_addr),
        .i_bank_sel  (i_bank_sel),
        .i_stall     (i_stall),
        .o_bram_addr (o_bram_addr),
        .o_wen       (o_wen),
        .o_ren       (o_ren),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    bram_burst_control #(
        .ADDR_W    (3),
        .BURST_LEN (1),
        .NUM_BANKS (4)
    ) u_dut1 (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (s_start),
        .i_rw        (s_rw),
        .i_base_addr (s_base_addr),
        .i_bank_sel  (s_bank_sel),
        .i_stall     (s_stall),
        .o_bram_addr (s_bram_addr),
        .o_wen       (s_wen),
        .o_ren       (s_ren),
        .o_busy      (s_busy),
        .o_done      (s_done),
        .o_err       (s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle, then compare the whole output set.
    task automatic expect_out(input string tag, input logic [3:0] addr,
                              input logic [1:0] wen, input logic [1:0] ren,
                              input logic busy, input logic done, input logic err);
        #1;
        check({tag, ".addr"}, 32'(o_bram_addr), 32'(addr));
        check({tag, ".wen"},  32'(o_wen),       32'(wen));
        check({tag, ".ren"},  32'(o_ren),       32'(ren));
        check({tag, ".busy"}, 32'(o_busy),      32'(busy));
        check({tag, ".done"}, 32'(o_done),      32'(done));
        check({tag, ".err"},  32'(o_err),       32'(err));
    endtask

    task automatic request(input logic rw, input logic [3:0] base, input logic [2:0] bank);
        i_start     = 1'b1;
        i_rw        = rw;
        i_base_addr = base;
        i_bank_sel  = bank;
        tick();
        i_start     = 1'b0;
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        i_rw        = 1'b0;
        i_base_addr = '0;
        i_bank_sel  = '0;
        i_stall     = 1'b0;
        s_start     = 1'b0;
        s_rw        = 1'b0;
        s_base_addr = '0;
        s_bank_sel  = '0;
        s_stall     = 1'b0;
        tick();
        tick();
        expect_out("reset", 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("reset.u1_addr", 32'(s_bram_addr), 32'd0);
        check("reset.u1_busy", 32'(s_busy), 32'd0);
        i_reset_n = 1'b1;
        tick();

        // Plain 4-beat write to bank 1 from address 2
        request(1'b1, 4'd2, 3'd1);
        for (int i = 0; i < 4; i++) begin
            expect_out("wr_beat", 4'(2 + i), 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_out("wr_done", 4'd6, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("wr_idle", 4'd6, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Read to bank 0 wrapping through address 15 -> 0
        request(1'b0, 4'd14, 3'd0);
        expect_out("rd_b0", 4'd14, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rd_b1", 4'd15, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rd_b2", 4'd0,  2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rd_b3", 4'd1,  2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rd_done", 4'd2, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("rd_idle", 4'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Write with a two-cycle stall on the second beat cycle
        request(1'b1, 4'd5, 3'd0);
        expect_out("st_b0", 4'd5, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        i_stall = 1'b1;
        expect_out("st_hold0", 4'd6, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("st_hold1", 4'd6, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        i_stall = 1'b0;
        expect_out("st_b1", 4'd6, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("st_b2", 4'd7, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("st_b3", 4'd8, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("st_done", 4'd9, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("st_idle", 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Start to a bank that does not exist
        i_start    = 1'b1;
        i_rw       = 1'b1;
        i_bank_sel = 3'd3;
        expect_out("err_req", 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        i_start = 1'b0;
        expect_out("err_pulse", 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("err_clear", 4'd9, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset after the second beat; a start during reset is ignored
        request(1'b1, 4'd0, 3'd1);
        expect_out("rst_b0", 4'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rst_b1", 4'd1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        i_reset_n = 1'b0;
        tick();
        expect_out("rst_idle", 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        i_start     = 1'b1;
        i_base_addr = 4'd12;
        tick();
        i_start   = 1'b0;
        i_reset_n = 1'b1;
        expect_out("rst_start_ign", 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rst_still_idle", 4'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        request(1'b1, 4'd3, 3'd1);
        for (int i = 0; i < 4; i++) begin
            expect_out("rst_new_beat", 4'(3 + i), 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_out("rst_new_done", 4'd7, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();

        // start held high through a whole read burst
        i_start     = 1'b1;
        i_rw        = 1'b0;
        i_base_addr = 4'd10;
        i_bank_sel  = 3'd1;
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_out("hold_beat", 4'(10 + i), 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_out("hold_done", 4'd14, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("hold_idle", 4'd14, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        i_base_addr = 4'd14;
        tick();
        i_start = 1'b0;
        expect_out("hold_2nd_b0", 4'd14, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("hold_2nd_b1", 4'd15, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("hold_2nd_done", 4'd2, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();

        // Single-beat instance: write to bank 2 at the top address
        s_start     = 1'b1;
        s_rw        = 1'b1;
        s_base_addr = 3'd7;
        s_bank_sel  = 3'd2;
        tick();
        s_start = 1'b0;
        #1;
        check("bl1.addr", 32'(s_bram_addr), 32'd7);
        check("bl1.wen",  32'(s_wen),       32'b0100);
        check("bl1.ren",  32'(s_ren),       32'b0000);
        check("bl1.busy", 32'(s_busy),      32'd1);
        tick();
        check("bl1.done",      32'(s_done),      32'd1);
        check("bl1.done_addr", 32'(s_bram_addr), 32'd0);
        check("bl1.done_wen",  32'(s_wen),       32'b0000);
        tick();
        check("bl1.idle_busy", 32'(s_busy), 32'd0);
        check("bl1.idle_done", 32'(s_done), 32'd0);
        check("bl1.err",       32'(s_err),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
